keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 238 +++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 3x4 matrix keypad scanner: column rotation, debounce, one-cycle key strobes.
// Optional auto-repeat of held digit keys when KEY_REPEAT_EN is defined.
module keypad_scan #(
  parameter int SCAN_DIV      = 2,
  parameter int DEBOUNCE_CNT  = 20,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keypad_row,
  output logic [2:0] keypad_col,
  output logic [9:0] num_input,
  output logic       set_time,
  output logic       clr_key,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    row_meta_q, rs_q;
  logic [2:0]    colp1_q, colp2_q;
  logic [2:0]    col_q, col_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    code_q, code_d;
  logic [9:0]    num_q, num_d;
  logic          set_q, set_d;
  logic          clr_q, clr_d;
  logic          held_q, held_d;

  // Decoded key for the captured row code and the frozen column
  logic       row_one;
  logic [1:0] row_idx, col_idx;
  logic [9:0] dig_oh;
  logic       is_hash, is_star;
  logic       settled;

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
  logic          rep_first_q, rep_first_d;
  logic [9:0]    rep_dig_q, rep_dig_d;
`endif

  always_comb begin
    row_one = 1'b1;
    row_idx = 2'd0;
    case (code_q)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_one = 1'b0;
    endcase
    case (col_q)
      3'b101:  col_idx = 2'd1;
      3'b011:  col_idx = 2'd2;
      default: col_idx = 2'd0;
    endcase
    dig_oh  = '0;
    is_hash = 1'b0;
    is_star = 1'b0;
    case ({row_idx, col_idx})
      4'b00_00: dig_oh[1] = 1'b1;
      4'b00_01: dig_oh[2] = 1'b1;
      4'b00_10: dig_oh[3] = 1'b1;
      4'b01_00: dig_oh[4] = 1'b1;
      4'b01_01: dig_oh[5] = 1'b1;
      4'b01_10: dig_oh[6] = 1'b1;
      4'b10_00: dig_oh[7] = 1'b1;
      4'b10_01: dig_oh[8] = 1'b1;
      4'b10_10: dig_oh[9] = 1'b1;
      4'b11_00: is_star   = 1'b1;
      4'b11_01: dig_oh[0] = 1'b1;
      4'b11_10: is_hash   = 1'b1;
      default: ;
    endcase
  end

  // rs lags the column drive by two cycles; colp2 is the column rs belongs to
  assign settled = (colp2_q == col_q);
  assign cnt_inc = (cnt_q >= CW'(DEBOUNCE_CNT)) ? cnt_q : cnt_q + CW'(1);

`ifdef KEY_REPEAT_EN
  assign rep_inc = (rep_cnt_q >= RW'(RMAX)) ? rep_cnt_q : rep_cnt_q + RW'(1);
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    num_d   = '0;
    set_d   = 1'b0;
    clr_d   = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_dig_d   = rep_dig_q;
`endif
    case (state_q)
      SCAN: begin
        if (rs_q != 4'hF) begin
          state_d = DEBOUNCE;
          code_d  = rs_q;
          cnt_d   = CW'(1);
          col_d   = colp2_q;
          div_d   = '0;
        end else if (div_q == DW'(SCAN_DIV - 1)) begin
          div_d = '0;
          col_d = {col_q[1:0], col_q[2]};
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      DEBOUNCE: begin
        // Samples still in flight from another column are neither counted nor fatal
        if (settled) begin
          if (rs_q != code_q) begin
            state_d = SCAN;
            cnt_d   = '0;
            code_d  = 4'hF;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CW'(DEBOUNCE_CNT)) begin
              state_d = PRESSED;
              cnt_d   = '0;
              if (row_one) begin
                num_d = dig_oh;
                set_d = is_hash;
                clr_d = is_star;
              end
`ifdef KEY_REPEAT_EN
              rep_cnt_d   = '0;
              rep_first_d = 1'b0;
              rep_dig_d   = row_one ? dig_oh : '0;
`endif
            end
          end
        end
      end
      PRESSED: begin
        if (rs_q == 4'hF) begin
          state_d = RELEASE;
          cnt_d   = CW'(1);
        end
`ifdef KEY_REPEAT_EN
        if (rep_dig_q != '0) begin
          if ((!rep_first_q && rep_inc == RW'(REPEAT_DELAY)) ||
              (rep_first_q && rep_inc == RW'(REPEAT_PERIOD))) begin
            num_d       = rep_dig_q;
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
          end else begin
            rep_cnt_d = rep_inc;
          end
        end
`endif
      end
      RELEASE: begin
        if (rs_q != 4'hF) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CW'(DEBOUNCE_CNT)) begin
            state_d = SCAN;
            cnt_d   = '0;
            code_d  = 4'hF;
            div_d   = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase
    held_d = (state_d == PRESSED) || (state_d == RELEASE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SCAN;
      row_meta_q <= 4'hF;
      rs_q       <= 4'hF;
      colp1_q    <= 3'b110;
      colp2_q    <= 3'b110;
      col_q      <= 3'b110;
      div_q      <= '0;
      cnt_q      <= '0;
      code_q     <= 4'hF;
      num_q      <= '0;
      set_q      <= 1'b0;
      clr_q      <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_meta_q <= keypad_row;
      rs_q       <= row_meta_q;
      colp1_q    <= col_q;
      colp2_q    <= colp1_q;
      col_q      <= col_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      num_q      <= num_d;
      set_q      <= set_d;
      clr_q      <= clr_d;
      held_q     <= held_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
      rep_dig_q   <= '0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      rep_dig_q   <= rep_dig_d;
    end
  end
`endif

  assign keypad_col = col_q;
  assign num_input  = num_q;
  assign set_time   = set_q;
  assign clr_key    = clr_q;
  assign key_held   = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: matrix keypad model, key-strobe scoreboard, reset and repeat checks.
module tb_keypad_scan;

  logic       clk;
  logic       rst;
  logic [3:0] keypad_row;
  logic [2:0] keypad_col;
  logic [9:0] num_input;
  logic       set_time;
  logic       clr_key;
  logic       key_held;

  logic [11:0] key_dn;     // pressed switches, index row*3+col
  int          n_vec;
  int          n_bad;
  int          cyc;
  int          sb[$];      // expected key codes: 0-9 digits, 10 '#', 11 '*'
  int          pulse_t[$]; // cycle stamp of each observed strobe
  logic        prev_any;
  int          code;

  keypad_scan dut (
    .clk        (clk),
    .rst        (rst),
    .keypad_row (keypad_row),
    .keypad_col (keypad_col),
    .num_input  (num_input),
    .set_time   (set_time),
    .clr_key    (clr_key),
    .key_held   (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  // A row reads low when any pressed switch on it sits on the driven column
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      keypad_row[r] = ~((key_dn[r*3+0] & ~keypad_col[0]) |
                        (key_dn[r*3+1] & ~keypad_col[1]) |
                        (key_dn[r*3+2] & ~keypad_col[2]));
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int kpos(input int key);
    if (key >= 1 && key <= 9) return key - 1;
    if (key == 0)  return 10;
    if (key == 11) return 9;
    return 11;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int key);
    key_dn[kpos(key)] = 1'b1;
  endtask

  task automatic release_key(input int key);
    key_dn[kpos(key)] = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: strobe exclusivity, width, and scoreboard comparison
  always @(negedge clk) begin
    if (!rst) begin
      chk("col_onehot", $countones(~keypad_col), 1);
      if ({num_input, set_time, clr_key} != '0) begin
        chk("exclusive", $countones({num_input, set_time, clr_key}), 1);
        chk("width", int'(prev_any), 0);
        code = -1;
        if (set_time) code = 10;
        else if (clr_key) code = 11;
        else for (int i = 0; i < 10; i++) if (num_input[i]) code = i;
        pulse_t.push_back(cyc);
        if (sb.size() == 0) chk("spurious", code, -1000);
        else chk("key", code, sb.pop_front());
        prev_any = 1'b1;
      end else begin
        prev_any = 1'b0;
      end
    end else begin
      prev_any = 1'b0;
    end
  end

  initial begin
    int n0;
    logic [2:0] seen;
    n_vec = 0;
    n_bad = 0;
    cyc = 0;
    prev_any = 1'b0;
    key_dn = '0;
    rst = 1'b1;
    tick(3);
    chk("rst_col", int'(keypad_col), 3'b110);
    chk("rst_num", int'(num_input), 0);
    chk("rst_set", int'(set_time), 0);
    chk("rst_clr", int'(clr_key), 0);
    chk("rst_held", int'(key_held), 0);
    rst = 1'b0;
    tick(5);

    // '5' held 100 cycles, then release debounce
    sb.push_back(5);
    press(5);
    tick(100);
    chk("held_5", int'(key_held), 1);
    release_key(5);
    tick(10);
    chk("held_rel", int'(key_held), 1);
    tick(30);
    chk("held_done", int'(key_held), 0);

    // '#' held 50 cycles
    sb.push_back(10);
    press(10);
    tick(50);
    release_key(10);
    tick(40);

    // '*' short hold
    sb.push_back(11);
    press(11);
    tick(50);
    release_key(11);
    tick(40);

    // '0' bouncing in 5-cycle toggles, then held stable
    sb.push_back(0);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) press(0); else release_key(0);
      tick(5);
    end
    press(0);
    tick(40);
    release_key(0);
    tick(40);

    // Glitch on '1' shorter than the debounce window
    press(1);
    tick(10);
    release_key(1);
    tick(30);
    chk("glitch_held", int'(key_held), 0);
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      if (keypad_col == 3'b110) seen[0] = 1'b1;
      if (keypad_col == 3'b101) seen[1] = 1'b1;
      if (keypad_col == 3'b011) seen[2] = 1'b1;
      tick(1);
    end
    chk("rotate", int'(seen), 7);

    // Ghost: '1' and '4' share column 0
    press(1);
    press(4);
    tick(50);
    chk("ghost_held", int'(key_held), 1);
    release_key(4);
    tick(40);
    chk("ghost_half", int'(key_held), 1);
    release_key(1);
    tick(40);
    chk("ghost_done", int'(key_held), 0);

    // Second key on the same column while held is ignored
    sb.push_back(2);
    press(2);
    tick(40);
    press(8);
    tick(40);
    release_key(2);
    tick(10);
    release_key(8);
    tick(40);
    chk("second_done", int'(key_held), 0);

    // Reset mid-debounce of '6'
    press(6);
    tick(15);
    rst = 1'b1;
    #1;
    chk("mid_col", int'(keypad_col), 3'b110);
    chk("mid_num", int'(num_input), 0);
    chk("mid_set", int'(set_time), 0);
    chk("mid_clr", int'(clr_key), 0);
    chk("mid_held", int'(key_held), 0);
    release_key(6);
    tick(3);
    rst = 1'b0;
    tick(50);
    chk("post_rst_held", int'(key_held), 0);

    // '7' held 1000 cycles
    n0 = pulse_t.size();
`ifdef KEY_REPEAT_EN
    repeat (4) sb.push_back(7);
`else
    sb.push_back(7);
`endif
    press(7);
    tick(1000);
    release_key(7);
    tick(40);
`ifdef KEY_REPEAT_EN
    chk("rep_count", pulse_t.size() - n0, 4);
    if (pulse_t.size() - n0 == 4) begin
      chk("rep_first", pulse_t[n0+1] - pulse_t[n0], 500);
      chk("rep_second", pulse_t[n0+2] - pulse_t[n0+1], 200);
      chk("rep_third", pulse_t[n0+3] - pulse_t[n0+2], 200);
    end
`else
    chk("rep_count", pulse_t.size() - n0, 1);
`endif

    tick(5);
    chk("pending", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
